claw_machine_pro: RTL and testbench

//  Parametrised second-generation claw machine controller.
//  - Adds a saturating credit bank, a configurable price per play and a play timer with auto-grab.
//  - Makes the guaranteed-win interval a parameter.
//  - Drives gantry motors, hoist, grip strength and chute release from player buttons and limit switches.
//  - Top-level controller; sits between the debounced switch inputs and the motor drivers.

---
 rtl/claw_machine_pro.sv | 250 +++++++++++++++++++++++++
 tb/tb_claw_machine_pro.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/claw_machine_pro.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// claw_machine_pro
//   Second-generation claw machine controller. Keeps a saturating credit bank,
//   charges PRICE credits per play, limits the player's MOVE time with an
//   automatic grab, and forces a tight grip every GUARANTEE_N-th consecutive
//   losing play.
//
//   Play sequence: IDLE -> MOVE -> DOWN -> GRIP -> RISE -> HOME -> OPEN -> IDLE
//
//   Build option:
//     CLAW_DOWN_WATCHDOG_EN  when defined, a descent that sees no Touch for
//                            DOWN_TICKS cycles proceeds to GRIP anyway.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   Coin                  coin switch, active low, one credit per falling edge
//   Mov_l/_r/_f/_b        player direction buttons, active high
//   Grab                  player grab button
//   Touch, Top, Origin    claw contact, hoist upper limit, gantry at chute
//   Drop                  prize chute sensor, active low
//   Claw_l/_r/_f/_b       gantry motors (combinational, MOVE only)
//   Down, Rise, Return    hoist down, hoist up, gantry homing
//   Open, Tight, Loose    claw open, strong grip, weak grip
//   Release               one-cycle pulse on entry to OPEN
//   Credits               current credit bank value
// -----------------------------------------------------------------------------
module claw_machine_pro #(
  parameter int CREDIT_W    = 4,
  parameter int PRICE       = 1,
  parameter int MOVE_TICKS  = 8,
  parameter int GUARANTEE_N = 10,
  parameter int OPEN_TICKS  = 2,
  parameter int DOWN_TICKS  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Coin,
  input  logic                Mov_l,
  input  logic                Mov_r,
  input  logic                Mov_f,
  input  logic                Mov_b,
  input  logic                Grab,
  input  logic                Touch,
  input  logic                Top,
  input  logic                Origin,
  input  logic                Drop,
  output logic                Claw_l,
  output logic                Claw_r,
  output logic                Claw_f,
  output logic                Claw_b,
  output logic                Down,
  output logic                Rise,
  output logic                Return,
  output logic                Open,
  output logic                Tight,
  output logic                Loose,
  output logic                Release,
  output logic [CREDIT_W-1:0] Credits
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MOVE,
    S_DOWN,
    S_GRIP,
    S_RISE,
    S_HOME,
    S_OPEN
  } state_t;

  // One shared timer serves every timed state; size it for the longest limit.
  localparam int MAX_MO    = (MOVE_TICKS > OPEN_TICKS) ? MOVE_TICKS : OPEN_TICKS;
  localparam int MAX_TICKS = (MAX_MO > DOWN_TICKS) ? MAX_MO : DOWN_TICKS;
  localparam int TIMER_W   = $clog2(MAX_TICKS + 1);
  localparam int LOSS_W    = (GUARANTEE_N > 1) ? $clog2(GUARANTEE_N) : 1;
  localparam int CW1       = CREDIT_W + 1;

  localparam logic [TIMER_W-1:0] MOVE_LAST = TIMER_W'(MOVE_TICKS - 1);
  localparam logic [TIMER_W-1:0] OPEN_LAST = TIMER_W'(OPEN_TICKS - 1);
`ifdef CLAW_DOWN_WATCHDOG_EN
  localparam logic [TIMER_W-1:0] DOWN_LAST = TIMER_W'(DOWN_TICKS - 1);
`endif
  localparam logic [LOSS_W-1:0]  LOSS_LAST = LOSS_W'(GUARANTEE_N - 1);
  localparam logic [CW1-1:0]     PRICE_EXT = CW1'(PRICE);
  localparam logic [CW1-1:0]     CRED_MAX  = {1'b0, {CREDIT_W{1'b1}}};

  state_t                state_reg, state_next;
  logic [TIMER_W-1:0]    timer_reg;
  logic [CREDIT_W-1:0]   credits_reg;
  logic [CW1-1:0]        credits_next;
  logic [LOSS_W-1:0]     loss_reg;
  logic                  win_reg, idle_first_reg;
  logic                  coin_s_reg, coin_d_reg, drop_s_reg, drop_d_reg;
  logic                  down_reg, rise_reg, return_reg, open_reg;
  logic                  tight_reg, loose_reg, release_reg;

  logic coin_fall, drop_fall, afford, deduct, move_exit, timing_state;
  logic win_window, win_now, open_exit, guarantee, grip_hold, move_entry;

  // Edges are taken between two registered samples of each active-low switch.
  assign coin_fall  = coin_d_reg & ~coin_s_reg;
  assign drop_fall  = drop_d_reg & ~drop_s_reg;
  assign afford     = ({1'b0, credits_reg} >= PRICE_EXT);
  assign deduct     = (state_reg == S_IDLE) && afford;
  assign guarantee  = (loss_reg == LOSS_LAST);
  assign open_exit  = (state_reg == S_OPEN) && (state_next == S_IDLE);
  assign move_entry = (state_reg != S_MOVE) && (state_next == S_MOVE);
  assign grip_hold  = (state_next == S_GRIP) || (state_next == S_RISE) ||
                      (state_next == S_HOME);

  // The prize can still fall after the claw reaches the chute, so the first
  // IDLE cycle still counts toward the play that just finished.
  assign win_window = (state_reg == S_RISE) || (state_reg == S_HOME) ||
                      (state_reg == S_OPEN) ||
                      ((state_reg == S_IDLE) && idle_first_reg);
  assign win_now    = win_reg | (drop_fall & win_window);

`ifdef CLAW_DOWN_WATCHDOG_EN
  assign timing_state = (state_reg == S_MOVE) || (state_reg == S_OPEN) ||
                        (state_reg == S_DOWN);
`else
  assign timing_state = (state_reg == S_MOVE) || (state_reg == S_OPEN);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and combinational gantry motors
  always_comb begin
    state_next = state_reg;
    move_exit  = 1'b0;
    Claw_l     = 1'b0;
    Claw_r     = 1'b0;
    Claw_f     = 1'b0;
    Claw_b     = 1'b0;
    case (state_reg)
      S_IDLE: if (afford) state_next = S_MOVE;
      S_MOVE: begin
        if (Grab || (timer_reg == MOVE_LAST)) begin
          state_next = S_DOWN;
          move_exit  = 1'b1;
        end
      end
`ifdef CLAW_DOWN_WATCHDOG_EN
      S_DOWN: if (Touch || (timer_reg == DOWN_LAST)) state_next = S_GRIP;
`else
      S_DOWN: if (Touch) state_next = S_GRIP;
`endif
      S_GRIP: state_next = S_RISE;
      S_RISE: if (Top) state_next = S_HOME;
      S_HOME: if (Origin) state_next = S_OPEN;
      S_OPEN: if (timer_reg == OPEN_LAST) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Motors follow the buttons only while the player is steering; an
    // opposing pair pressed together cancels out, and the exit cycle is quiet.
    if ((state_reg == S_MOVE) && !move_exit) begin
      Claw_l = Mov_l & ~Mov_r;
      Claw_r = Mov_r & ~Mov_l;
      Claw_f = Mov_f & ~Mov_b;
      Claw_b = Mov_b & ~Mov_f;
    end
  end

  // Credit bank: deduction can never underflow (afford gates it), and a coin
  // on the deduct cycle cannot overflow, so saturation applies only otherwise.
  always_comb begin
    credits_next = {1'b0, credits_reg} + {{CREDIT_W{1'b0}}, coin_fall};
    if (deduct) begin
      credits_next = credits_next - PRICE_EXT;
    end else if (credits_next > CRED_MAX) begin
      credits_next = CRED_MAX;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coin_s_reg     <= 1'b1;
      coin_d_reg     <= 1'b1;
      drop_s_reg     <= 1'b1;
      drop_d_reg     <= 1'b1;
      credits_reg    <= '0;
      timer_reg      <= '0;
      loss_reg       <= '0;
      win_reg        <= 1'b0;
      idle_first_reg <= 1'b0;
      down_reg       <= 1'b0;
      rise_reg       <= 1'b0;
      return_reg     <= 1'b0;
      open_reg       <= 1'b1;
      tight_reg      <= 1'b0;
      loose_reg      <= 1'b0;
      release_reg    <= 1'b0;
    end else begin
      coin_s_reg  <= Coin;
      coin_d_reg  <= coin_s_reg;
      drop_s_reg  <= Drop;
      drop_d_reg  <= drop_s_reg;
      credits_reg <= credits_next[CREDIT_W-1:0];

      if ((state_next != state_reg) || !timing_state) begin
        timer_reg <= '0;
      end else begin
        timer_reg <= timer_reg + TIMER_W'(1);
      end

      if (move_entry) begin
        win_reg <= 1'b0;
      end else if (drop_fall && win_window) begin
        win_reg <= 1'b1;
      end

      idle_first_reg <= open_exit;

      // A guaranteed play always restarts the count, win or not.
      if (open_exit) begin
        loss_reg <= (win_now || guarantee) ? '0 : loss_reg + LOSS_W'(1);
      end else if ((state_reg == S_IDLE) && idle_first_reg && drop_fall) begin
        loss_reg <= '0;
      end

      down_reg    <= (state_next == S_DOWN);
      rise_reg    <= (state_next == S_RISE);
      return_reg  <= (state_next == S_HOME);
      open_reg    <= (state_next == S_IDLE) || (state_next == S_DOWN) ||
                     (state_next == S_OPEN);
      tight_reg   <= grip_hold && guarantee;
      loose_reg   <= grip_hold && !guarantee;
      release_reg <= (state_next == S_OPEN) && (state_reg != S_OPEN);
    end
  end

  assign Down    = down_reg;
  assign Rise    = rise_reg;
  assign Return  = return_reg;
  assign Open    = open_reg;
  assign Tight   = tight_reg;
  assign Loose   = loose_reg;
  assign Release = release_reg;
  assign Credits = credits_reg;

endmodule

// File: tb/tb_claw_machine_pro.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_claw_machine_pro
//   Drives whole plays with randomized button patterns, grab timing, wins and
//   coin bursts; a play-level model (credit count, consecutive-loss count)
//   predicts credits and the grip chosen on each play. A second instance with
//   PRICE=2 checks that a single credit does not start a play.
// -----------------------------------------------------------------------------
module tb_claw_machine_pro;
  localparam int CREDIT_W    = 4;
  localparam int CRED_MAX    = 15;
  localparam int MOVE_TICKS  = 8;
  localparam int GUARANTEE_N = 10;
  localparam int DOWN_TICKS  = 16;

  logic clk = 1'b0;
  logic rst_n, Coin, Mov_l, Mov_r, Mov_f, Mov_b, Grab, Touch, Top, Origin, Drop;
  logic Claw_l, Claw_r, Claw_f, Claw_b, Down, Rise, Return, Open, Tight, Loose, Release;
  logic [CREDIT_W-1:0] Credits;
  logic coin2;
  logic c2_l, c2_r, c2_f, c2_b, down2, rise2, ret2, open2, tight2, loose2, rel2;
  logic [CREDIT_W-1:0] credits2;

  int n_checks = 0;
  int n_errors = 0;
  int m_cred   = 0;   // model credit bank
  int m_loss   = 0;   // model consecutive losing plays
  int play_no  = 0;

  always #5 clk = ~clk;

  claw_machine_pro u_dut (
    .clk(clk), .rst_n(rst_n), .Coin(Coin), .Mov_l(Mov_l), .Mov_r(Mov_r),
    .Mov_f(Mov_f), .Mov_b(Mov_b), .Grab(Grab), .Touch(Touch), .Top(Top),
    .Origin(Origin), .Drop(Drop), .Claw_l(Claw_l), .Claw_r(Claw_r),
    .Claw_f(Claw_f), .Claw_b(Claw_b), .Down(Down), .Rise(Rise),
    .Return(Return), .Open(Open), .Tight(Tight), .Loose(Loose),
    .Release(Release), .Credits(Credits)
  );

  claw_machine_pro #(.PRICE(2)) u_dut_p2 (
    .clk(clk), .rst_n(rst_n), .Coin(coin2), .Mov_l(Mov_l), .Mov_r(Mov_r),
    .Mov_f(Mov_f), .Mov_b(Mov_b), .Grab(Grab), .Touch(Touch), .Top(Top),
    .Origin(Origin), .Drop(Drop), .Claw_l(c2_l), .Claw_r(c2_r),
    .Claw_f(c2_f), .Claw_b(c2_b), .Down(down2), .Rise(rise2),
    .Return(ret2), .Open(open2), .Tight(tight2), .Loose(loose2),
    .Release(rel2), .Credits(credits2)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (play %0d): got %0d expected %0d", tag, play_no, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic insert_coin();
    Coin = 1'b0;
    tick();
    Coin = 1'b1;
    tick();
    m_cred = (m_cred < CRED_MAX) ? m_cred + 1 : CRED_MAX;
  endtask

  task automatic drop_pulse();
    Drop = 1'b0;
    tick();
    Drop = 1'b1;
  endtask

  function automatic logic [31:0] motors();
    return {28'd0, Claw_l, Claw_r, Claw_f, Claw_b};
  endfunction

  // where: 0 RISE, 1 HOME, 2 OPEN, 3 first IDLE cycle
  task automatic run_play(input bit timeout, input bit win, input int where,
                          input int coins, input bit long_down, input bit abort_rise);
    bit exp_tight;
    bit l, r, f, b;
    int k;
    play_no++;
    if (m_cred < 1) begin
      insert_coin();
      check_value("coin_credit", Credits, m_cred);
    end
    tick();                               // IDLE -> MOVE with deduction
    m_cred -= 1;
    check_value("deduct", Credits, m_cred);
    Mov_r = 1'b1; #1;
    check_value("mirror_r", motors(), 32'b0100);
    Mov_l = 1'b1; #1;
    check_value("opposed_lr", motors(), 32'b0000);
    Mov_l = 1'b0; Mov_r = 1'b0;
    if (timeout) begin
      repeat (MOVE_TICKS - 2) tick();     // last non-exit MOVE cycle
      Mov_f = 1'b1; #1;
      check_value("pre_exit_f", motors(), 32'b0010);
      tick();                             // exit cycle: motors quiet
      check_value("exit_motor", motors(), 32'b0000);
      check_value("timeout_no_down", Down, 1'b0);
      Mov_f = 1'b0;
      tick();
    end else begin
      k = $urandom_range(0, 4);
      repeat (k) begin
        tick();
        {l, r, f, b} = 4'($urandom);
        Mov_l = l; Mov_r = r; Mov_f = f; Mov_b = b; #1;
        check_value("mirror_rand", motors(), {28'd0, l & ~r, r & ~l, f & ~b, b & ~f});
      end
      Grab = 1'b1; #1;
      check_value("grab_exit_motor", motors(), 32'b0000);
      tick();
      Grab = 1'b0; Mov_l = 1'b0; Mov_r = 1'b0; Mov_f = 1'b0; Mov_b = 1'b0;
    end
    check_value("down", Down, 1'b1);
    check_value("down_open", Open, 1'b1);
    Mov_l = 1'b1; Mov_f = 1'b1; #1;
    check_value("down_no_motor", motors(), 32'b0000);
    Mov_l = 1'b0; Mov_f = 1'b0;
    if (long_down) begin
`ifdef CLAW_DOWN_WATCHDOG_EN
      repeat (DOWN_TICKS - 1) tick();
      check_value("wd_still_down", Down, 1'b1);
      tick();
      check_value("wd_grip", Down, 1'b0);
`else
      repeat (100) tick();
      check_value("down_persists", Down, 1'b1);
      Touch = 1'b1; tick(); Touch = 1'b0;
`endif
    end else begin
      Touch = 1'b1; tick(); Touch = 1'b0;
    end
    exp_tight = (m_loss == GUARANTEE_N - 1);
    check_value("grip_open", Open, 1'b0);
    check_value("grip_tight", Tight, exp_tight);
    check_value("grip_loose", Loose, !exp_tight);
    tick();                               // RISE
    check_value("rise", Rise, 1'b1);
    check_value("rise_tight", Tight, exp_tight);
    if (abort_rise) begin
      rst_n = 1'b0; #1;
      check_value("rst_rise", Rise, 1'b0);
      check_value("rst_open", Open, 1'b1);
      check_value("rst_credits", Credits, 0);
      m_cred = 0; m_loss = 0;
      tick();
      rst_n = 1'b1;
      tick();
      $display("play %0d: aborted by reset in RISE", play_no);
      return;
    end
    repeat (coins) insert_coin();
    if (coins > 0) check_value("coin_burst", Credits, m_cred);
    if (win && where == 0) drop_pulse();
    Top = 1'b1; tick(); Top = 1'b0;       // HOME
    check_value("home_return", Return, 1'b1);
    check_value("home_loose", Loose, !exp_tight);
    if (win && where == 1) drop_pulse();
    Origin = 1'b1; tick(); Origin = 1'b0; // OPEN cycle 0
    check_value("release_pulse", Release, 1'b1);
    check_value("open0", Open, 1'b1);
    check_value("open0_grip", Tight | Loose, 1'b0);
    if (win && where == 2) Drop = 1'b0;
    tick();                               // OPEN cycle 1
    check_value("release_once", Release, 1'b0);
    check_value("open1", Open, 1'b1);
    Drop = 1'b1;
    if (win && where == 3) Drop = 1'b0;
    tick();                               // first IDLE cycle
    check_value("idle_open", Open, 1'b1);
    check_value("idle_return", Return, 1'b0);
    Drop = 1'b1;
    m_loss = (win || m_loss == GUARANTEE_N - 1) ? 0 : m_loss + 1;
    $display("play %0d: tight=%0d win=%0d where=%0d timeout=%0d credits=%0d losses=%0d",
             play_no, exp_tight, win, where, timeout, m_cred, m_loss);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; Coin = 1'b1; Drop = 1'b1; coin2 = 1'b1;
    Mov_l = 1'b0; Mov_r = 1'b0; Mov_f = 1'b0; Mov_b = 1'b0;
    Grab = 1'b0; Touch = 1'b0; Top = 1'b0; Origin = 1'b0;
    repeat (3) tick();
    check_value("reset_open", Open, 1'b1);
    check_value("reset_credits", Credits, 0);
    check_value("reset_outs", {Down, Rise, Return, Tight, Loose, Release}, 0);
    check_value("reset_motors", motors(), 0);
    rst_n = 1'b1;
    tick();

    // PRICE=2: one credit must not start a play
    coin2 = 1'b0; tick(); coin2 = 1'b1; tick();
    check_value("p2_one_credit", credits2, 1);
    repeat (5) tick();
    check_value("p2_stays_idle", credits2, 1);
    check_value("p2_idle_open", open2, 1'b1);
    coin2 = 1'b0; tick(); coin2 = 1'b1; tick();
    check_value("p2_two_credits", credits2, 2);
    tick();
    check_value("p2_deduct", credits2, 0);

    // Plays 1..11 lose: 10th is guaranteed, 11th back to loose
    for (int i = 1; i <= 11; i++) begin
      run_play(i == 2, 1'b0, 0, 0, i == 3, 1'b0);
    end
    // Coin burst saturates the bank; then a win resets the loss streak
    run_play(1'b0, 1'b0, 0, 17, 1'b0, 1'b0);
    run_play(1'b0, 1'b1, 1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      run_play($urandom_range(0, 3) == 0, 1'b0, 0, 0, 1'b0, 1'b0);
    end
    // Randomized mix of wins, win timing, timeouts and coin bursts
    for (int i = 0; i < 14; i++) begin
      run_play($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 3), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0,
               1'b0, 1'b0);
    end
    run_play(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    run_play(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
